// File: rtl/bank_pkg.sv
// Shared defaults, FSM state encoding and descriptor layout for bank_burst_master.
package bank_pkg;
  localparam int NUM_BANKS  = 5;
  localparam int ADDR_WIDTH = 9;
  localparam int DATA_WIDTH = 32;
  localparam int LEN_WIDTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  typedef struct packed {
    logic                  rw;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  len;
    logic [NUM_BANKS-1:0]  mask;
  } desc_t;
endpackage

// File: rtl/bank_burst_master_if.sv
// Slot-side bus between a burst master and one slot of the bank RAM subsystem.
interface bank_burst_master_if #(
  parameter int NUM_BANKS  = bank_pkg::NUM_BANKS,
  parameter int ADDR_WIDTH = bank_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = bank_pkg::DATA_WIDTH
);
  logic                            cmd_valid;
  logic                            cmd_ready;
  logic                            cmd_rw;
  logic [NUM_BANKS-1:0]            cmd_mask;
  logic [ADDR_WIDTH-1:0]           cmd_addr;
  logic                            wvalid;
  logic                            wready;
  logic [NUM_BANKS*DATA_WIDTH-1:0] wdata;
  logic                            rvalid;
  logic [NUM_BANKS*DATA_WIDTH-1:0] rdata;

  modport master (
    output cmd_valid, cmd_rw, cmd_mask, cmd_addr, wvalid, wdata,
    input  cmd_ready, wready, rvalid, rdata
  );

  modport slave (
    input  cmd_valid, cmd_rw, cmd_mask, cmd_addr, wvalid, wdata,
    output cmd_ready, wready, rvalid, rdata
  );
endinterface

// File: rtl/bank_rd_fifo.sv
// First-word-fall-through read-return buffer; DEPTH must be a power of two.
module bank_rd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             full, do_push, do_pop;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == (PTR_W+1)'(DEPTH));
  assign do_pop    = pop && !empty;
  // A push into a full buffer is fine when the head leaves in the same cycle.
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem_reg[rd_ptr_reg];
  assign count     = count_reg;

  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/bank_burst_master.sv
// Descriptor-driven burst master for one bank RAM slot: write stream in, read stream out.
// Defining BANK_BURST_PERF_EN adds saturating stall and beat counters.
module bank_burst_master
  import bank_pkg::*;
#(
  parameter int NUM_BANKS     = bank_pkg::NUM_BANKS,
  parameter int ADDR_WIDTH    = bank_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH    = bank_pkg::DATA_WIDTH,
  parameter int LEN_WIDTH     = bank_pkg::LEN_WIDTH,
  parameter int RD_FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            desc_valid,
  output logic                            desc_ready,
  input  logic                            desc_rw,
  input  logic [ADDR_WIDTH-1:0]           desc_addr,
  input  logic [LEN_WIDTH-1:0]            desc_len,
  input  logic [NUM_BANKS-1:0]            desc_mask,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] s_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] m_data,
  output logic                            done,
  bank_burst_master_if.master             slot
`ifdef BANK_BURST_PERF_EN
  ,
  output logic [31:0]                     perf_stall_cycles,
  output logic [31:0]                     perf_beats
`endif
);
  localparam int CNT_W = $clog2(RD_FIFO_DEPTH) + 1;

  state_t                          state_reg;
  desc_t                           desc_reg;
  logic                            beat_full_reg, cmd_done_reg, w_done_reg;
  logic [NUM_BANKS*DATA_WIDTH-1:0] beat_data_reg;
  logic [CNT_W-1:0]                outstanding_reg;
  logic [CNT_W-1:0]                fifo_count;
  logic [CNT_W:0]                  in_flight;
  logic                            fifo_empty, credit_ok, last_beat;
  logic                            cmd_hs, w_hs, s_hs, m_pop, rd_push, cmd_hs_rd, beat_retire;

  assign in_flight   = {1'b0, outstanding_reg} + {1'b0, fifo_count};
  assign credit_ok   = in_flight < (CNT_W+1)'(RD_FIFO_DEPTH);
  assign last_beat   = (desc_reg.len == '0);
  assign cmd_hs      = slot.cmd_valid && slot.cmd_ready;
  assign w_hs        = slot.wvalid && slot.wready;
  assign s_hs        = s_valid && s_ready;
  assign m_pop       = m_valid && m_ready;
  assign cmd_hs_rd   = cmd_hs && (state_reg == ST_READ);
  // Returns only count while a read is in flight; stale ones after a reset are dropped.
  assign rd_push     = slot.rvalid && (state_reg == ST_READ || state_reg == ST_DRAIN)
                       && (outstanding_reg != '0);
  assign beat_retire = (state_reg == ST_WRITE) && beat_full_reg
                       && (cmd_done_reg || cmd_hs) && (w_done_reg || w_hs);

  always_comb begin
    desc_ready     = (state_reg == ST_IDLE);
    s_ready        = (state_reg == ST_WRITE) && !beat_full_reg;
    slot.cmd_valid = ((state_reg == ST_WRITE) && beat_full_reg && !cmd_done_reg)
                     || ((state_reg == ST_READ) && credit_ok);
    slot.cmd_rw    = (state_reg == ST_WRITE);
    slot.cmd_addr  = desc_reg.addr;
    slot.cmd_mask  = desc_reg.mask;
    slot.wvalid    = (state_reg == ST_WRITE) && beat_full_reg && !w_done_reg;
    slot.wdata     = beat_data_reg;
    done           = (beat_retire && last_beat)
                     || ((state_reg == ST_DRAIN) && (outstanding_reg == '0)
                         && (fifo_count == CNT_W'(1)) && m_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      desc_reg      <= '0;
      beat_full_reg <= 1'b0;
      cmd_done_reg  <= 1'b0;
      w_done_reg    <= 1'b0;
      beat_data_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (desc_valid) begin
            desc_reg  <= '{rw: desc_rw, addr: desc_addr, len: desc_len, mask: desc_mask};
            state_reg <= desc_rw ? ST_WRITE : ST_READ;
          end
        end
        ST_WRITE: begin
          if (s_hs) begin
            beat_full_reg <= 1'b1;
            beat_data_reg <= s_data;
          end
          if (beat_retire) begin
            beat_full_reg <= 1'b0;
            cmd_done_reg  <= 1'b0;
            w_done_reg    <= 1'b0;
            desc_reg.addr <= desc_reg.addr + ADDR_WIDTH'(1);
            if (last_beat) state_reg <= ST_IDLE;
            else           desc_reg.len <= desc_reg.len - LEN_WIDTH'(1);
          end else begin
            if (cmd_hs) cmd_done_reg <= 1'b1;
            if (w_hs)   w_done_reg   <= 1'b1;
          end
        end
        ST_READ: begin
          if (cmd_hs) begin
            desc_reg.addr <= desc_reg.addr + ADDR_WIDTH'(1);
            if (last_beat) state_reg <= ST_DRAIN;
            else           desc_reg.len <= desc_reg.len - LEN_WIDTH'(1);
          end
        end
        default: begin
          if (done) state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding_reg <= '0;
    end else begin
      case ({cmd_hs_rd, rd_push})
        2'b10:   outstanding_reg <= outstanding_reg + CNT_W'(1);
        2'b01:   outstanding_reg <= outstanding_reg - CNT_W'(1);
        default: outstanding_reg <= outstanding_reg;
      endcase
    end
  end

  bank_rd_fifo #(
    .DEPTH (RD_FIFO_DEPTH),
    .WIDTH (NUM_BANKS*DATA_WIDTH)
  ) u_rd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_push),
    .push_data (slot.rdata),
    .pop       (m_pop),
    .head_data (m_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign m_valid = !fifo_empty;

`ifdef BANK_BURST_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_beats        <= '0;
    end else begin
      if (slot.cmd_valid && !slot.cmd_ready && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if ((beat_retire || cmd_hs_rd) && (perf_beats != '1))
        perf_beats <= perf_beats + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_bank_burst_master.sv
// Directed bench for bank_burst_master: vector table of bursts plus hand-written corner sequences.
module tb_bank_burst_master;
  localparam int NB = 5, AW = 9, DW = 32, LW = 8, DEPTH = 4, LAT = 2;
  localparam int BW = NB * DW;

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic [NB-1:0] mask;
    logic [31:0]   base;
    logic [NB-1:0] exp_bmask;
    int            exp_beats;
    logic [AW-1:0] exp_last;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          desc_valid, desc_ready, desc_rw;
  logic [AW-1:0] desc_addr;
  logic [LW-1:0] desc_len;
  logic [NB-1:0] desc_mask;
  logic          s_valid, s_ready, m_valid, m_ready, done;
  logic [BW-1:0] s_data, m_data;
  logic          cmd_ready_en = 1'b1;
  logic          wready_en = 1'b1;
`ifdef BANK_BURST_PERF_EN
  logic [31:0]   perf_stall_cycles, perf_beats;
`endif

  bank_burst_master_if #(.NUM_BANKS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) slot ();
  assign slot.cmd_ready = cmd_ready_en;
  assign slot.wready    = wready_en;

  bank_burst_master #(
    .NUM_BANKS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .RD_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_rw(desc_rw),
    .desc_addr(desc_addr), .desc_len(desc_len), .desc_mask(desc_mask),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .done(done), .slot(slot)
`ifdef BANK_BURST_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_beats(perf_beats)
`endif
  );

  logic [BW-1:0] mem [512];
  logic [AW-1:0] cmd_addr_q[$];
  logic          cmd_rw_q[$];
  logic [NB-1:0] cmd_mask_q[$];
  logic [BW-1:0] rx_q[$];
  logic [BW-1:0] src_q[$];
  logic [AW-1:0] wr_addr_pend[$];
  logic [NB-1:0] wr_mask_pend[$];
  logic [BW-1:0] wr_data_pend[$];
  logic [AW-1:0] rd_addr_pend[$];
  int            rd_due[$];
  int            done_cnt = 0;
  int            cyc = 0;
  int            chk_cnt = 0;
  int            pass_cnt = 0;

  function automatic logic [BW-1:0] rep(input logic [31:0] w);
    logic [BW-1:0] r;
    for (int k = 0; k < NB; k++) r[k*DW +: DW] = w;
    return r;
  endfunction

  task automatic check(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h", name, got, exp);
  endtask

  // Slot model: memory with masked writes and fixed-latency read returns, plus monitors.
  initial begin
    logic [BW-1:0] wd, nrd;
    logic [NB-1:0] wm;
    logic [AW-1:0] wa;
    logic          nrv;
    for (int i = 0; i < 512; i++) mem[i] = '0;
    slot.rvalid = 1'b0;
    slot.rdata  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (slot.cmd_valid && slot.cmd_ready) begin
          cmd_addr_q.push_back(slot.cmd_addr);
          cmd_rw_q.push_back(slot.cmd_rw);
          cmd_mask_q.push_back(slot.cmd_mask);
          if (slot.cmd_rw) begin
            wr_addr_pend.push_back(slot.cmd_addr);
            wr_mask_pend.push_back(slot.cmd_mask);
          end else begin
            rd_addr_pend.push_back(slot.cmd_addr);
            rd_due.push_back(cyc + LAT);
          end
        end
        if (slot.wvalid && slot.wready) wr_data_pend.push_back(slot.wdata);
        if (m_valid && m_ready) rx_q.push_back(m_data);
        if (done) done_cnt++;
      end
      while (wr_addr_pend.size() > 0 && wr_data_pend.size() > 0) begin
        wa = wr_addr_pend.pop_front();
        wm = wr_mask_pend.pop_front();
        wd = wr_data_pend.pop_front();
        for (int k = 0; k < NB; k++)
          if (wm[k]) mem[wa][k*DW +: DW] = wd[k*DW +: DW];
      end
      nrv = 1'b0;
      nrd = '0;
      if (rd_addr_pend.size() > 0 && rd_due[0] <= cyc) begin
        nrv = 1'b1;
        nrd = mem[rd_addr_pend.pop_front()];
        void'(rd_due.pop_front());
      end
      @(posedge clk);
      #1;
      slot.rvalid = nrv;
      slot.rdata  = nrd;
    end
  end

  // Write-stream source fed from src_q.
  initial begin
    s_valid = 1'b0;
    s_data  = '0;
    forever begin
      @(negedge clk);
      if (s_valid && s_ready) void'(src_q.pop_front());
      @(posedge clk);
      #1;
      if (src_q.size() > 0) begin
        s_valid = 1'b1;
        s_data  = src_q[0];
      end else begin
        s_valid = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_desc(input logic rw, input logic [AW-1:0] a, input logic [LW-1:0] l,
                           input logic [NB-1:0] m);
    bit ok = 1'b0;
    desc_valid = 1'b1;
    desc_rw    = rw;
    desc_addr  = a;
    desc_len   = l;
    desc_mask  = m;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (desc_ready) ok = 1'b1;
    end
    check("desc_accept", BW'(ok), BW'(1));
    @(posedge clk);
    #1;
    desc_valid = 1'b0;
  endtask

  task automatic wait_done(input int start, input int budget, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != start) seen = 1'b1;
    end
    check(name, BW'(seen), BW'(1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t          vecs[8];
    int            d0, c0, r0;
    bit            ok;
    logic [BW-1:0] exp;
    logic [AW-1:0] ea;

    vecs[0] = '{1'b1, 9'h00A, 8'd3, 5'h1F, 32'hAAAA0000, 5'h1F, 4, 9'h00D};
    vecs[1] = '{1'b0, 9'h00A, 8'd3, 5'h1F, 32'hAAAA0000, 5'h1F, 4, 9'h00D};
    vecs[2] = '{1'b1, 9'h1FE, 8'd2, 5'h1F, 32'hBBBB0000, 5'h1F, 3, 9'h000};
    vecs[3] = '{1'b0, 9'h1FE, 8'd2, 5'h1F, 32'hBBBB0000, 5'h1F, 3, 9'h000};
    vecs[4] = '{1'b1, 9'h050, 8'd0, 5'h00, 32'hCCCC0000, 5'h00, 1, 9'h050};
    vecs[5] = '{1'b1, 9'h050, 8'd0, 5'h05, 32'hDDDD0000, 5'h05, 1, 9'h050};
    vecs[6] = '{1'b0, 9'h050, 8'd0, 5'h1F, 32'hDDDD0000, 5'h05, 1, 9'h050};
    vecs[7] = '{1'b1, 9'h100, 8'd7, 5'h1F, 32'hEEEE0000, 5'h1F, 8, 9'h107};

    desc_valid = 1'b0;
    desc_rw    = 1'b0;
    desc_addr  = '0;
    desc_len   = '0;
    desc_mask  = '0;
    m_ready    = 1'b1;

    // Reset values while rst is held
    #1 rst = 1'b1;
    #1;
    check("reset_outputs", BW'({desc_ready, slot.cmd_valid, slot.wvalid, s_ready, m_valid, done}),
          BW'(6'b100000));
    step(3);
    rst = 1'b0;
    step(2);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].rw)
        for (int n = 0; n <= int'(vecs[i].len); n++) src_q.push_back(rep(vecs[i].base + n));
      d0 = done_cnt;
      c0 = cmd_addr_q.size();
      r0 = rx_q.size();
      send_desc(vecs[i].rw, vecs[i].addr, vecs[i].len, vecs[i].mask);
      wait_done(d0, 200, $sformatf("v%0d_done", i));
      step(4);
      check($sformatf("v%0d_beats", i), BW'(cmd_addr_q.size() - c0), BW'(vecs[i].exp_beats));
      check($sformatf("v%0d_one_done", i), BW'(done_cnt - d0), BW'(1));
      check($sformatf("v%0d_last_addr", i), BW'(cmd_addr_q[cmd_addr_q.size()-1]), BW'(vecs[i].exp_last));
      ok = 1'b1;
      for (int n = 0; n < vecs[i].exp_beats; n++) begin
        ea = vecs[i].addr + AW'(n);
        if (cmd_addr_q[c0+n] !== ea || cmd_rw_q[c0+n] !== vecs[i].rw || cmd_mask_q[c0+n] !== vecs[i].mask)
          ok = 1'b0;
      end
      check($sformatf("v%0d_cmd_seq", i), BW'(ok), BW'(1));
      if (!vecs[i].rw) begin
        check($sformatf("v%0d_rx_count", i), BW'(rx_q.size() - r0), BW'(vecs[i].exp_beats));
        for (int n = 0; n < vecs[i].exp_beats && r0 + n < rx_q.size(); n++) begin
          for (int k = 0; k < NB; k++)
            exp[k*DW +: DW] = vecs[i].exp_bmask[k] ? (vecs[i].base + n) : 32'h0;
          check($sformatf("v%0d_rx%0d", i, n), rx_q[r0+n], exp);
        end
      end
    end

    // Read 8 beats with m_ready low: credit stops issue at the FIFO depth
    m_ready = 1'b0;
    d0 = done_cnt;
    c0 = cmd_addr_q.size();
    r0 = rx_q.size();
    send_desc(1'b0, 9'h100, 8'd7, 5'h1F);
    step(30);
    check("credit_cmds", BW'(cmd_addr_q.size() - c0), BW'(DEPTH));
    @(negedge clk);
    #1;
    check("credit_cmd_valid_low", BW'(slot.cmd_valid), BW'(0));
    check("credit_m_valid", BW'(m_valid), BW'(1));
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    wait_done(d0, 200, "credit_done");
    step(4);
    check("credit_total_cmds", BW'(cmd_addr_q.size() - c0), BW'(8));
    check("credit_rx_count", BW'(rx_q.size() - r0), BW'(8));
    for (int n = 0; n < 8 && r0 + n < rx_q.size(); n++)
      check($sformatf("credit_rx%0d", n), rx_q[r0+n], rep(32'hEEEE0000 + n));

    // Write with wready held off after the command handshake
    wready_en = 1'b0;
    d0 = done_cnt;
    c0 = cmd_addr_q.size();
    src_q.push_back(rep(32'h12340000));
    send_desc(1'b1, 9'h020, 8'd0, 5'h1F);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (cmd_addr_q.size() != c0) ok = 1'b1;
    end
    check("wdelay_cmd_hs", BW'(ok), BW'(1));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("wdelay_hold%0d", i), BW'({slot.cmd_valid, slot.wvalid}), BW'(2'b01));
    end
    @(posedge clk);
    #1;
    wready_en = 1'b1;
    wait_done(d0, 50, "wdelay_done");
    step(4);
    check("wdelay_single_cmd", BW'(cmd_addr_q.size() - c0), BW'(1));
    check("wdelay_one_done", BW'(done_cnt - d0), BW'(1));
    check("wdelay_mem", mem[9'h020], rep(32'h12340000));

    // Reset in the middle of a read burst
    d0 = done_cnt;
    c0 = cmd_addr_q.size();
    send_desc(1'b0, 9'h00A, 8'd7, 5'h1F);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (cmd_addr_q.size() - c0 >= 2) ok = 1'b1;
    end
    check("abort_two_cmds", BW'(ok), BW'(1));
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_rst_outputs", BW'({desc_ready, slot.cmd_valid, slot.wvalid, s_ready, m_valid, done}),
          BW'(6'b100000));
    step(2);
    rst = 1'b0;
    r0 = rx_q.size();
    step(10);
    check("abort_no_done", BW'(done_cnt - d0), BW'(0));
    check("abort_stale_ignored", BW'({m_valid, BW'(rx_q.size() - r0)}), BW'(0));
    d0 = done_cnt;
    c0 = cmd_addr_q.size();
    src_q.push_back(rep(32'h5A5A0000));
    src_q.push_back(rep(32'h5A5A0001));
    send_desc(1'b1, 9'h030, 8'd1, 5'h1F);
    wait_done(d0, 100, "after_abort_done");
    step(4);
    check("after_abort_cmds", BW'(cmd_addr_q.size() - c0), BW'(2));
    check("after_abort_mem0", mem[9'h030], rep(32'h5A5A0000));
    check("after_abort_mem1", mem[9'h031], rep(32'h5A5A0001));

`ifdef BANK_BURST_PERF_EN
    // Five stall cycles on a one-beat write
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
    check("perf_reset", BW'({perf_stall_cycles, perf_beats}), BW'(0));
    cmd_ready_en = 1'b0;
    d0 = done_cnt;
    src_q.push_back(rep(32'h77770000));
    send_desc(1'b1, 9'h040, 8'd0, 5'h1F);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (slot.cmd_valid) ok = 1'b1;
    end
    check("perf_cmd_valid_seen", BW'(ok), BW'(1));
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    cmd_ready_en = 1'b1;
    wait_done(d0, 50, "perf_done");
    step(2);
    check("perf_stall_cycles", BW'(perf_stall_cycles), BW'(5));
    check("perf_beats", BW'(perf_beats), BW'(1));
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
